muldiv_sched_unit: RTL and testbench
====================================

Name: muldiv_sched_unit

Overview:
- Multi-cycle multiply/divide engine and scheduler for the HI/LO resource of the MIPS core.
- Sits in EX next to the forwarding/hazard logic:
  - accepts MULT/MULTU/DIV/DIVU from EX;
  - holds the pipeline with stall_req while iterating;
  - presents a one-cycle result_valid with the HI/LO values.
- EX forwards these values as ex_write_hi_value / ex_write_lo_value with ex_is_write_hi/lo.

Parameters:
- DATA_W, 32, operand width; only 32 is supported (ISA-fixed).
- DIV0_LO, 32'hFFFF_FFFF, LO value produced on divide-by-zero.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  EX holds a mul/div instruction; held high while stalled
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- src_a  in  32  rs value (dividend / multiplicand)
- src_b  in  32  rt value (divisor / multiplier)
- cancel  in  1  exception/flush; aborts the operation in flight
- stall_req  out  1  freeze PC, IF/ID and ID/EX
- busy  out  1  state != IDLE
- result_valid  out  1  one-cycle pulse; hi_out/lo_out are new this cycle
- hi_out  out  32  HI result (upper product / remainder)
- lo_out  out  32  LO result (lower product / quotient)

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE, counter=0;
  - hi_out=lo_out=0; stall_req=busy=result_valid=0.
  - Reset mid-operation discards all work.
- State machine: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
- IDLE:
  - start & ~cancel: latch op and |src_a|, |src_b| (absolute values only for signed ops).
  - Latch result signs: sign_q=a31^b31, sign_r=a31 (signed ops only).
  - Clear partial accumulator and counter=0; go to CALC.
- CALC: one radix-2 step per cycle for exactly 32 cycles (counter 0..31), then FIXUP.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
- FIXUP (1 cycle):
  - Apply two's-complement negation per the latched signs.
  - Register the final values into hi_out/lo_out.
  - Go to DONE.
- DONE (1 cycle):
  - result_valid=1, stall_req=0; go to IDLE.
  - start is ignored in DONE: the same instruction is leaving EX.
- stall_req = (IDLE & start & ~cancel) | CALC | FIXUP, forced 0 when cancel=1.
- Latency: start seen in cycle 0.
  - stall_req high in cycles 0..33 (34 cycles).
  - result_valid high in cycle 34.
  - Back-to-back start is accepted in cycle 35.
- Arithmetic:
  - MULT: signed 64-bit product; MULTU: unsigned. HI=[63:32], LO=[31:0].
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign. DIVU: unsigned.
  - Divide-by-zero still takes 34 cycles. Result: LO=DIV0_LO, HI=src_a (unchanged dividend, sign preserved).
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0 (wrap, no trap).
- cancel:
  - In CALC/FIXUP: IDLE on the next edge; hi_out/lo_out unchanged; no result_valid.
  - In DONE: result_valid is gated to 0, but hi_out/lo_out have already updated. EX must not commit.
  - In IDLE with start: no latch, stall_req=0.
- hi_out/lo_out hold their value between completions; they change only on the FIXUP edge.

Test Plan:
- Reset: resetn low mid-CALC, then high -> state IDLE; hi_out=lo_out=0; stall_req=0; busy=0.
- MULTU: a=0xFFFF_FFFF, b=0xFFFF_FFFF -> stall_req 34 cycles; then result_valid pulse with HI=0xFFFF_FFFE, LO=0x0000_0001.
- MULT: a=-3 (0xFFFF_FFFD), b=7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- DIV:
  - a=-7, b=2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1).
  - DIVU a=100, b=0 -> LO=0xFFFF_FFFF, HI=100.
  - DIV 0x8000_0000 / -1 -> LO=0x8000_0000, HI=0.
- Cancel: start DIVU, assert cancel in CALC cycle 10 -> stall_req drops the same cycle; IDLE next edge; no result_valid; prior hi_out/lo_out retained.
- Back-to-back: start held through DONE -> no re-issue in DONE; a new start in cycle 35 is accepted with stall_req high that same cycle.

Source files
------------

// File: rtl/muldiv_sched_unit.sv
// Multi-cycle multiply/divide engine for the HI/LO resource.
// A radix-2 datapath does shift-add for multiply and restoring
// shift-subtract for divide on operand magnitudes. The signs are
// applied in a single fixup cycle. The pipeline is held via
// stall_req, and each completion is announced by a one-cycle
// result_valid pulse.
module muldiv_sched_unit #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              cancel,
  output logic              stall_req,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Magnitude of a two's-complement value (0x8000_0000 maps to itself, read unsigned).
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]          state_r;
  logic [4:0]          cnt_r;
  logic                is_div_r;
  logic                sign_q_r;
  logic                sign_r_r;
  logic [DATA_W-1:0]   opa_r;      // multiplicand magnitude
  logic [DATA_W-1:0]   opb_r;      // divisor magnitude
  logic [DATA_W-1:0]   a_raw_r;    // original dividend, returned on divide-by-zero
  logic [DATA_W-1:0]   acc_hi_r;   // upper product / partial remainder
  logic [DATA_W-1:0]   acc_lo_r;   // multiplier-lower product / dividend-quotient

  logic                accept_s;
  logic                op_signed_s;
  logic [DATA_W-1:0]   a_mag_s;
  logic [DATA_W-1:0]   b_mag_s;
  logic [DATA_W:0]     mul_sum_s;
  logic [DATA_W:0]     rem_sh_s;
  logic                rem_ge_s;
  logic [DATA_W-1:0]   rem_sub_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   res_hi_s;
  logic [DATA_W-1:0]   res_lo_s;

  // Operand conditioning and acceptance of a new instruction.
  always_comb begin
    accept_s    = (state_r == S_IDLE) & start & ~cancel;
    op_signed_s = ~op[0];
    a_mag_s     = op_signed_s ? abs_val(src_a) : src_a;
    b_mag_s     = op_signed_s ? abs_val(src_b) : src_b;
  end

  // One radix-2 step for each algorithm; the state selects which one is kept.
  always_comb begin
    mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opa_r} : {(DATA_W+1){1'b0}});
    rem_sh_s  = {acc_hi_r, acc_lo_r[DATA_W-1]};
    rem_ge_s  = (rem_sh_s >= {1'b0, opb_r});
    rem_sub_s = rem_sh_s[DATA_W-1:0] - opb_r;
  end

  // Final sign fixup and the divide-by-zero override.
  always_comb begin
    prod_s   = {acc_hi_r, acc_lo_r};
    res_hi_s = acc_hi_r;
    res_lo_s = acc_lo_r;
    if (is_div_r) begin
      if (opb_r == {DATA_W{1'b0}}) begin
        res_hi_s = a_raw_r;
        res_lo_s = DIV0_LO;
      end else begin
        res_lo_s = sign_q_r ? (~acc_lo_r + {{(DATA_W-1){1'b0}}, 1'b1}) : acc_lo_r;
        res_hi_s = sign_r_r ? (~acc_hi_r + {{(DATA_W-1){1'b0}}, 1'b1}) : acc_hi_r;
      end
    end else begin
      if (sign_q_r) begin
        prod_s = ~prod_s + {{(2*DATA_W-1){1'b0}}, 1'b1};
      end else begin
        prod_s = {acc_hi_r, acc_lo_r};
      end
      res_hi_s = prod_s[2*DATA_W-1:DATA_W];
      res_lo_s = prod_s[DATA_W-1:0];
    end
  end

  // Scheduler FSM and iterative datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= S_IDLE;
      cnt_r    <= 5'd0;
      is_div_r <= 1'b0;
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      opa_r    <= {DATA_W{1'b0}};
      opb_r    <= {DATA_W{1'b0}};
      a_raw_r  <= {DATA_W{1'b0}};
      acc_hi_r <= {DATA_W{1'b0}};
      acc_lo_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            is_div_r <= op[1];
            sign_q_r <= op_signed_s & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            sign_r_r <= op_signed_s & src_a[DATA_W-1];
            opa_r    <= a_mag_s;
            opb_r    <= b_mag_s;
            a_raw_r  <= src_a;
            acc_hi_r <= {DATA_W{1'b0}};
            acc_lo_r <= op[1] ? a_mag_s : b_mag_s;
            cnt_r    <= 5'd0;
            state_r  <= S_CALC;
          end
        end
        S_CALC: begin
          if (cancel) begin
            state_r <= S_IDLE;
          end else begin
            if (is_div_r) begin
              acc_hi_r <= rem_ge_s ? rem_sub_s : rem_sh_s[DATA_W-1:0];
              acc_lo_r <= {acc_lo_r[DATA_W-2:0], rem_ge_s};
            end else begin
              acc_hi_r <= mul_sum_s[DATA_W:1];
              acc_lo_r <= {mul_sum_s[0], acc_lo_r[DATA_W-1:1]};
            end
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
              state_r <= S_FIXUP;
            end
          end
        end
        S_FIXUP: state_r <= cancel ? S_IDLE : S_DONE;
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Architectural HI/LO results change only on an uncancelled fixup edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_out <= {DATA_W{1'b0}};
      lo_out <= {DATA_W{1'b0}};
    end else if ((state_r == S_FIXUP) && !cancel) begin
      hi_out <= res_hi_s;
      lo_out <= res_lo_s;
    end
  end

  // Handshake outputs towards the hazard unit and EX.
  always_comb begin
    stall_req    = ~cancel & (accept_s | (state_r == S_CALC) | (state_r == S_FIXUP));
    busy         = (state_r != S_IDLE);
    result_valid = (state_r == S_DONE) & ~cancel;
  end

endmodule

// File: tb/tb_muldiv_sched_unit.sv
// Self-checking bench for muldiv_sched_unit: directed corner cases, cancel,
// reset and back-to-back issue, plus randomized operations checked against
// a plain-arithmetic reference model.
module tb_muldiv_sched_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stall_req;
  logic        busy;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int          checks;
  int          errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_sched_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .cancel       (cancel),
    .stall_req    (stall_req),
    .busy         (busy),
    .result_valid (result_valid),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {HI, LO} straight from the ISA arithmetic rules.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      2'b11: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Issues one op in the next cycle, leaves start high so DONE sees it held.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int          n_stall;
    int          rv_cycle;
    e        = model(o, a, b);
    n_stall  = 0;
    rv_cycle = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
      end
      #1;
      if (stall_req) n_stall++;
      if (c == 33) chk("hi_hold", {32'd0, hi_out}, {32'd0, exp_hi});
      if (result_valid) begin
        rv_cycle = c;
        break;
      end
    end
    chk("rv_cycle", 64'(rv_cycle), 64'd34);
    chk("stall_cnt", 64'(n_stall), 64'd34);
    chk("hi", {32'd0, hi_out}, {32'd0, e[63:32]});
    chk("lo", {32'd0, lo_out}, {32'd0, e[31:0]});
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  initial begin
    int          rv_cnt;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0;
    errors = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    resetn = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    src_a  = 32'd0;
    src_b  = 32'd0;
    cancel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hi", {32'd0, hi_out}, 64'd0);
    chk("rst_lo", {32'd0, lo_out}, 64'd0);
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rv", {63'd0, result_valid}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed arithmetic corners, issued back-to-back.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0);

    // start held through DONE must not re-issue.
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("no_reissue_busy", {63'd0, busy}, 64'd0);

    // Cancel in CALC counter step 10.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    src_a = 32'd1000;
    src_b = 32'd7;
    repeat (11) @(negedge clk);
    cancel = 1'b1;
    #1;
    chk("cancel_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    cancel = 1'b0;
    start  = 1'b0;
    #1;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    rv_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (result_valid) rv_cnt++;
    end
    chk("cancel_no_rv", 64'(rv_cnt), 64'd0);
    chk("cancel_hi", {32'd0, hi_out}, {32'd0, exp_hi});
    chk("cancel_lo", {32'd0, lo_out}, {32'd0, exp_lo});

    // Cancel in IDLE together with start.
    @(negedge clk);
    start  = 1'b1;
    cancel = 1'b1;
    #1;
    chk("idle_cancel_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    #1;
    chk("idle_cancel_busy", {63'd0, busy}, 64'd0);

    // Randomized operations with optional idle gaps.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        3: rb = 32'd0 - 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        start = 1'b0;
      end
    end

    // Asynchronous reset in the middle of CALC discards the work.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    src_a = 32'h1234_5678;
    src_b = 32'h9ABC_DEF0;
    repeat (15) @(negedge clk);
    start = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_hi", {32'd0, hi_out}, 64'd0);
    chk("mid_rst_lo", {32'd0, lo_out}, 64'd0);
    chk("mid_rst_stall", {63'd0, stall_req}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
